dadda_mac: RTL and testbench
============================

DADDA_MAC -- requirements
Module: dadda_mac

Interface
REQ-001 SHALL have parameter ACC_W, default 40: accumulator and result width in bits, legal range 32..48.
REQ-002 SHALL have port clk, input, 1 bit: the single clock, with all state updated on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have in_valid (input, 1), in_ready (output, 1), in_a (input, 16), in_b (input, 16) and in_last (input, 1): one operand pair per handshake, with in_last marking the final term of a burst.
REQ-005 SHALL have out_valid (output, 1), out_ready (input, 1), out_sum (output, ACC_W), out_count (output, 8) and out_ovf (output, 1): the burst result.

Function
REQ-006 SHALL accept an input beat when in_valid && in_ready at a rising edge, and SHALL register in_a, in_b and in_last into stage-1 (s1_valid set).
REQ-007 SHALL form the product of the stage-1 operands through the dadda_mul instance, 16x16 unsigned to 32 bits, purely combinationally.
REQ-008 SHALL define stall = s1_valid && s1_last && out_valid && !out_ready.
REQ-009 SHALL drive in_ready = !stall, combinationally.
REQ-010 SHALL hold stage-1 and the accumulator unchanged while stall is 1.
REQ-011 SHALL, on each s1_valid && !stall edge, set acc <= acc + zero-extended product modulo 2^ACC_W.
REQ-012 SHALL, on the same edge, increment cnt, saturating at 255.
REQ-013 SHALL, on the same edge, set ovf <= ovf | carry-out of the addition.
REQ-014 SHALL, when the stage-1 term is last (not stalled), load out_sum with the new acc value, out_count with the new cnt value and out_ovf with the new ovf value, and set out_valid.
REQ-015 SHALL, on that same edge, clear acc, cnt and ovf to 0 so the next burst starts clean.
REQ-016 SHALL give a latency of 2 edges: a last beat accepted at edge k produces out_valid high after edge k+1.
REQ-017 SHALL clear out_valid on out_valid && out_ready, except when a new result loads on the same edge, in which case the load wins and out_valid stays 1.
REQ-018 SHALL hold out_sum, out_count and out_ovf stable while out_valid && !out_ready.
REQ-019 SHALL clear s1_valid on an edge where no beat is accepted and stage-1 is not stalled.
REQ-020 SHALL sustain a throughput of one beat per cycle when not stalled, including back-to-back single-term bursts.
REQ-021 SHALL treat in_a, in_b and in_last as don't-care when in_valid is 0.

Reset
REQ-022 SHALL, while rst=1 at an edge, set s1_valid=0, acc=0, cnt=0, ovf=0, out_valid=0, out_sum=0, out_count=0 and out_ovf=0.
REQ-023 SHALL drive in_ready=1 from the first edge after reset, and SHALL discard any partial burst or undelivered result.
REQ-024 SHALL give rst priority over every other event in the same cycle.

Structure
REQ-025 SHALL take constants OP_W=16, PROD_W=32 and CNT_W=8 from shared package dadda_pkg.
REQ-026 SHALL instantiate exactly one sub-module, the existing combinational dadda_mul (a, b, result), fed from the stage-1 registers.
REQ-027 SHALL keep all sequential logic in dadda_mac and none in dadda_mul.

Verification
REQ-028 SHALL cover a single term: (3,5,last) with out_ready=1 -> out_valid 2 edges later with sum=15, count=1, ovf=0.
REQ-029 SHALL cover a 4-beat burst of (65535,65535), last on the 4th -> sum=17179344900, count=4, ovf=0.
REQ-030 SHALL cover wrap-around: with ACC_W=32, two beats of (65535,65535) -> sum=4294705154, ovf=1, and the next burst (1,1,last) -> sum=1, ovf=0.
REQ-031 SHALL cover backpressure: out_ready=0 with bursts (2,2,last) then (4,4,last) -> first result held, in_ready=0 while second last is in stage-1; out_ready=1 -> sums 4 then 16 delivered in order, none lost.
REQ-032 SHALL cover reset mid-burst: (7,7) and (9,9) without last, rst for 1 cycle, then (2,2,last) -> sum=4, count=1.
REQ-033 SHALL cover a zero operand plus count saturation: (0,65535,last) -> sum=0, count=1; a 300-beat burst of (1,1) -> sum=300, count=255.

Source files
------------

// File: rtl/dadda_pkg.sv
// Shared widths and helpers for the Dadda multiply-accumulate datapath.
package dadda_pkg;

    localparam int OP_W     = 16;
    localparam int PROD_W   = 32;
    localparam int CNT_W    = 8;
    localparam int N_STAGES = 6;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Dadda column-height targets for a 16-row partial-product matrix, tallest first.
    localparam int DADDA_D [N_STAGES] = '{13, 9, 6, 4, 3, 2};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dadda_mul.sv
// Unsigned 16x16 multiplier: AND-array partial products, Dadda column reduction
// to two rows, then one carry-propagate add. Purely combinational.
module dadda_mul
    import dadda_pkg::*;
(
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic [PROD_W-1:0] result
);

    // One spare column catches carries out of the MSB; the product cannot reach it.
    localparam int NCOL = PROD_W + 1;

    always_comb begin : reduce
        logic [OP_W-1:0]   col [NCOL];
        logic [OP_W-1:0]   nxt [NCOL];
        int                h   [NCOL];
        int                nh  [NCOL];
        int                p;
        int                tot;
        logic              s;
        logic              cy;
        logic [PROD_W-1:0] row0;
        logic [PROD_W-1:0] row1;

        p    = 0;
        tot  = 0;
        s    = 1'b0;
        cy   = 1'b0;
        row0 = '0;
        row1 = '0;
        for (int c = 0; c < NCOL; c++) begin
            col[c] = '0;
            nxt[c] = '0;
            h[c]   = 0;
            nh[c]  = 0;
        end

        for (int i = 0; i < OP_W; i++) begin
            for (int j = 0; j < OP_W; j++) begin
                col[i+j][h[i+j]] = a[i] & b[j];
                h[i+j]           = h[i+j] + 1;
            end
        end

        // Columns are walked LSB first so each one sees the carries its neighbour
        // just produced; reduce only as far as the stage target, half adder at d+1.
        for (int st = 0; st < N_STAGES; st++) begin
            for (int c = 0; c < NCOL; c++) begin
                nxt[c] = '0;
                nh[c]  = 0;
            end
            for (int c = 0; c < PROD_W; c++) begin
                p   = 0;
                tot = h[c] + nh[c];
                for (int k = 0; k < OP_W; k++) begin
                    if (tot > DADDA_D[st]) begin
                        if (tot == DADDA_D[st] + 1) begin
                            s   = col[c][p] ^ col[c][p+1];
                            cy  = col[c][p] & col[c][p+1];
                            p   = p + 2;
                            tot = tot - 1;
                        end else begin
                            s   = col[c][p] ^ col[c][p+1] ^ col[c][p+2];
                            cy  = (col[c][p] & col[c][p+1]) |
                                  (col[c][p+2] & (col[c][p] ^ col[c][p+1]));
                            p   = p + 3;
                            tot = tot - 2;
                        end
                        nxt[c][nh[c]]     = s;
                        nh[c]             = nh[c] + 1;
                        nxt[c+1][nh[c+1]] = cy;
                        nh[c+1]           = nh[c+1] + 1;
                    end
                end
                for (int k = 0; k < OP_W; k++) begin
                    if (k >= p && k < h[c]) begin
                        nxt[c][nh[c]] = col[c][k];
                        nh[c]         = nh[c] + 1;
                    end
                end
            end
            for (int c = 0; c < NCOL; c++) begin
                col[c] = nxt[c];
                h[c]   = nh[c];
            end
        end

        for (int c = 0; c < PROD_W; c++) begin
            row0[c] = col[c][0];
            row1[c] = col[c][1];
        end
        result = row0 + row1;
    end

endmodule

// File: rtl/dadda_mac.sv
// Burst multiply-accumulate: operand stage, then accumulate/result stage (2-edge latency).
// A last term held in stage 1 against an unconsumed result stalls input via in_ready.
module dadda_mac
    import dadda_pkg::*;
#(
    parameter int ACC_W = 40
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_sum,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [OP_W-1:0]   s1_a_q,     s1_a_d;
    logic [OP_W-1:0]   s1_b_q,     s1_b_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic              ovf_q,      ovf_d;
    logic              out_vld_q,  out_vld_d;
    logic [ACC_W-1:0]  out_sum_q,  out_sum_d;
    logic [CNT_W-1:0]  out_cnt_q,  out_cnt_d;
    logic              out_ovf_q,  out_ovf_d;

    logic [PROD_W-1:0] prod;
    logic [ACC_W-1:0]  acc_sum;
    logic              carry;
    logic [CNT_W-1:0]  cnt_inc;
    logic              stall;
    logic              accept;
    logic              step;

    dadda_mul u_mul (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .result (prod)
    );

    assign stall    = s1_valid_q && s1_last_q && out_vld_q && !out_ready;
    assign in_ready = !stall;
    assign accept   = in_valid && !stall;
    assign step     = s1_valid_q && !stall;

    assign {carry, acc_sum} = {1'b0, acc_q} + {1'b0, ACC_W'(prod)};
    assign cnt_inc          = sat_inc(cnt_q);

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        out_vld_d  = out_vld_q;
        out_sum_d  = out_sum_q;
        out_cnt_d  = out_cnt_q;
        out_ovf_d  = out_ovf_q;

        if (!stall) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_last_d = in_last;
                s1_a_d    = in_a;
                s1_b_d    = in_b;
            end
        end

        if (out_vld_q && out_ready) begin
            out_vld_d = 1'b0;
        end

        // A fresh result load overrides the consume-side clear above.
        if (step) begin
            acc_d = acc_sum;
            cnt_d = cnt_inc;
            ovf_d = ovf_q | carry;
            if (s1_last_q) begin
                out_vld_d = 1'b1;
                out_sum_d = acc_sum;
                out_cnt_d = cnt_inc;
                out_ovf_d = ovf_q | carry;
                acc_d     = '0;
                cnt_d     = '0;
                ovf_d     = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            out_vld_q  <= 1'b0;
            out_sum_q  <= '0;
            out_cnt_q  <= '0;
            out_ovf_q  <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_a_q     <= s1_a_d;
            s1_b_q     <= s1_b_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            out_vld_q  <= out_vld_d;
            out_sum_q  <= out_sum_d;
            out_cnt_q  <= out_cnt_d;
            out_ovf_q  <= out_ovf_d;
        end
    end

    assign out_valid = out_vld_q;
    assign out_sum   = out_sum_q;
    assign out_count = out_cnt_q;
    assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_dadda_mac.sv
// Scoreboard bench for dadda_mac: default 40-bit instance plus a 32-bit instance for wrap-around.
module tb_dadda_mac;

    typedef struct packed {
        logic [63:0] sum;
        logic [7:0]  cnt;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  in_valid;
    logic [1:0]  in_last;
    logic [1:0]  out_ready;
    logic [15:0] in_a [2];
    logic [15:0] in_b [2];
    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [39:0] out_sum0;
    logic [31:0] out_sum1;
    logic [7:0]  out_count0, out_count1;
    logic        out_ovf0, out_ovf1;

    res_t exp0[$];
    res_t rcv0[$];
    res_t exp1[$];
    res_t rcv1[$];
    res_t r;
    res_t e;
    int   checks = 0;
    int   passes = 0;
    int   stall_cycles = 0;

    always #5 clk = ~clk;

    dadda_mac u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready0),
        .in_a(in_a[0]), .in_b(in_b[0]), .in_last(in_last[0]),
        .out_valid(out_valid0), .out_ready(out_ready[0]), .out_sum(out_sum0),
        .out_count(out_count0), .out_ovf(out_ovf0)
    );

    dadda_mac #(.ACC_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready1),
        .in_a(in_a[1]), .in_b(in_b[1]), .in_last(in_last[1]),
        .out_valid(out_valid1), .out_ready(out_ready[1]), .out_sum(out_sum1),
        .out_count(out_count1), .out_ovf(out_ovf1)
    );

    // A result is taken on the edge following a negedge where valid and ready are both high.
    always @(negedge clk) begin
        if (!rst && out_valid0 && out_ready[0]) rcv0.push_back({24'd0, out_sum0, out_count0, out_ovf0});
        if (!rst && out_valid1 && out_ready[1]) rcv1.push_back({32'd0, out_sum1, out_count1, out_ovf1});
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    // Called just after a rising edge; returns just after the edge that accepts the beat.
    task automatic send(input int s, input logic [15:0] a, input logic [15:0] b, input logic last);
        int g = 0;
        in_valid[s] = 1'b1;
        in_a[s]     = a;
        in_b[s]     = b;
        in_last[s]  = last;
        @(negedge clk);
        while (((s == 0) ? in_ready0 : in_ready1) !== 1'b1 && g < 500) begin
            stall_cycles++;
            g++;
            @(negedge clk);
        end
        if (g >= 500) begin
            checks++;
            $display("FAIL send_timeout inst=%0d in_ready=0 want 1", s);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int s);
        in_valid[s] = 1'b0;
        in_a[s]     = 16'($urandom);
        in_b[s]     = 16'($urandom);
        in_last[s]  = 1'b1;
    endtask

    task automatic wait_rcv(input int s, input int n);
        int g = 0;
        while (((s == 0) ? rcv0.size() : rcv1.size()) < n && g < 1000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            checks++;
            $display("FAIL rcv_timeout inst=%0d got=%0d want=%0d", s,
                     (s == 0) ? rcv0.size() : rcv1.size(), n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle(0);
        idle(1);
        out_ready = 2'b11;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid0); else passes++;
        checks++; if (out_sum0 !== 40'd0) $display("FAIL reset_out_sum got=%0d want=0", out_sum0); else passes++;
        checks++; if (out_count0 !== 8'd0) $display("FAIL reset_out_count got=%0d want=0", out_count0); else passes++;
        checks++; if (out_ovf0 !== 1'b0) $display("FAIL reset_out_ovf got=%b want=0", out_ovf0); else passes++;
        checks++; if (in_ready0 !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready0); else passes++;
        checks++; if (out_valid1 !== 1'b0) $display("FAIL reset_out_valid32 got=%b want=0", out_valid1); else passes++;
    endtask

    task automatic test_single();
        @(posedge clk); #1;
        exp0.push_back({64'd15, 8'd1, 1'b0});
        send(0, 16'd3, 16'd5, 1'b1);
        idle(0);
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b0) $display("FAIL single_latency_early got=%b want=0", out_valid0); else passes++;
        @(negedge clk);
        checks++; if (out_valid0 !== 1'b1) $display("FAIL single_latency got=%b want=1", out_valid0); else passes++;
        wait_rcv(0, 1);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL single got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_burst4();
        @(posedge clk); #1;
        exp0.push_back({64'd17179344900, 8'd4, 1'b0});
        for (int i = 0; i < 4; i++) send(0, 16'hFFFF, 16'hFFFF, i == 3);
        idle(0);
        wait_rcv(0, 1);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL burst4 got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_wrap();
        @(posedge clk); #1;
        exp1.push_back({64'd4294705154, 8'd2, 1'b1});
        exp1.push_back({64'd1, 8'd1, 1'b0});
        send(1, 16'hFFFF, 16'hFFFF, 1'b0);
        send(1, 16'hFFFF, 16'hFFFF, 1'b1);
        send(1, 16'd1, 16'd1, 1'b1);
        idle(1);
        wait_rcv(1, 2);
        while (rcv1.size() > 0 && exp1.size() > 0) begin
            r = rcv1.pop_front(); e = exp1.pop_front(); checks++;
            if (r !== e) $display("FAIL wrap got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_backpressure();
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        exp0.push_back({64'd4, 8'd1, 1'b0});
        exp0.push_back({64'd16, 8'd1, 1'b0});
        send(0, 16'd2, 16'd2, 1'b1);
        send(0, 16'd4, 16'd4, 1'b1);
        idle(0);
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b0) $display("FAIL bp_in_ready got=%b want=0", in_ready0); else passes++;
        checks++; if (out_valid0 !== 1'b1) $display("FAIL bp_out_valid got=%b want=1", out_valid0); else passes++;
        checks++; if (out_sum0 !== 40'd4) $display("FAIL bp_first_sum got=%0d want=4", out_sum0); else passes++;
        repeat (3) @(negedge clk);
        checks++;
        if (out_sum0 !== 40'd4 || out_count0 !== 8'd1 || in_ready0 !== 1'b0)
            $display("FAIL bp_hold got sum=%0d cnt=%0d in_ready=%b want sum=4 cnt=1 in_ready=0", out_sum0, out_count0, in_ready0);
        else passes++;
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        wait_rcv(0, 2);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL backpressure got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        send(0, 16'd7, 16'd7, 1'b0);
        send(0, 16'd9, 16'd9, 1'b0);
        idle(0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (in_ready0 !== 1'b1) $display("FAIL midrst_in_ready got=%b want=1", in_ready0); else passes++;
        @(posedge clk); #1;
        exp0.push_back({64'd4, 8'd1, 1'b0});
        send(0, 16'd2, 16'd2, 1'b1);
        idle(0);
        wait_rcv(0, 1);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL reset_mid got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_zero_sat();
        @(posedge clk); #1;
        exp0.push_back({64'd0, 8'd1, 1'b0});
        exp0.push_back({64'd300, 8'd255, 1'b0});
        send(0, 16'd0, 16'hFFFF, 1'b1);
        for (int i = 0; i < 300; i++) send(0, 16'd1, 16'd1, i == 299);
        idle(0);
        wait_rcv(0, 2);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL zero_sat got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        logic [15:0] b;
        @(posedge clk); #1;
        stall_cycles = 0;
        for (int i = 0; i < 10; i++) begin
            a = (i == 0) ? 16'hFFFF : (i == 1) ? 16'h8000 : 16'($urandom);
            b = (i == 0) ? 16'h0001 : (i == 1) ? 16'hFFFF : 16'($urandom);
            exp0.push_back({64'(a) * 64'(b), 8'd1, 1'b0});
            send(0, a, b, 1'b1);
        end
        idle(0);
        checks++; if (stall_cycles !== 0) $display("FAIL b2b_throughput stall_cycles=%0d want 0", stall_cycles); else passes++;
        wait_rcv(0, 10);
        while (rcv0.size() > 0 && exp0.size() > 0) begin
            r = rcv0.pop_front(); e = exp0.pop_front(); checks++;
            if (r !== e) $display("FAIL back_to_back got sum=%0d cnt=%0d ovf=%0d want sum=%0d cnt=%0d ovf=%0d", r.sum, r.cnt, r.ovf, e.sum, e.cnt, e.ovf);
            else passes++;
        end
    endtask

    task automatic test_drain();
        repeat (5) @(negedge clk);
        checks++;
        if (exp0.size() != 0 || rcv0.size() != 0 || exp1.size() != 0 || rcv1.size() != 0)
            $display("FAIL drain leftover exp0=%0d rcv0=%0d exp1=%0d rcv1=%0d want all 0", exp0.size(), rcv0.size(), exp1.size(), rcv1.size());
        else passes++;
    endtask

    initial begin
        in_valid  = 2'b00;
        in_last   = 2'b00;
        out_ready = 2'b11;
        in_a[0] = '0; in_a[1] = '0;
        in_b[0] = '0; in_b[1] = '0;
        test_reset();
        test_single();
        test_burst4();
        test_wrap();
        test_backpressure();
        test_reset_mid();
        test_zero_sat();
        test_back_to_back();
        test_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
